// File: rtl/fifo_wr_ctrl_p.sv
// Write-side pointer controller for the dual-clock FIFO.
// Owns the binary/Gray write pointers, synchronises the read Gray pointer
// into the write domain and derives full, almost-full, fill level and a
// sticky overflow flag.
module fifo_wr_ctrl_p #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  WR_CLK,
    input  logic                  WR_RST,
    input  logic                  WR_INC,
    input  logic                  OVF_CLR,
    input  logic [ADDR_WIDTH:0]   GRAY_RD_PTR,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [ADDR_WIDTH:0]   GRAY_WR_PTR,
    output logic                  WR_FULL,
    output logic                  WR_ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   WR_COUNT,
    output logic                  WR_OVERFLOW
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] THRESH = (AW+1)'(AFULL_THRESH);

    logic [AW:0] wbin_q,  wbin_d;
    logic [AW:0] gray_q,  gray_d;
    logic [AW:0] count_q, count_d;
    logic        full_q,  full_d;
    logic        afull_q, afull_d;
    logic        ovf_q,   ovf_d;
    logic [AW:0] sync_q [SYNC_STAGES];
    logic [AW:0] rgray_s;
    logic [AW:0] rbin_s;

    assign rgray_s = sync_q[SYNC_STAGES-1];

    // Next-state pointer, status and overflow computation
    always_comb begin
        WR_EN   = WR_INC & ~full_q;
        wbin_d  = wbin_q + {{AW{1'b0}}, WR_EN};
        gray_d  = wbin_d ^ (wbin_d >> 1);

        rbin_s     = '0;
        rbin_s[AW] = rgray_s[AW];
        for (int unsigned i = 0; i < AW; i++) begin
            rbin_s[AW-1-i] = rbin_s[AW-i] ^ rgray_s[AW-1-i];
        end

        // Full when the next write pointer is exactly one lap ahead of the
        // synchronised read pointer: top two Gray bits inverted, rest equal.
        full_d  = (gray_d == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
        count_d = wbin_d - rbin_s;
        afull_d = (count_d >= THRESH);
        // A rejected write sets the flag; set takes priority over clear.
        ovf_d   = (WR_INC & full_q) | (ovf_q & ~OVF_CLR);
    end

    // Pointer, status and read-pointer synchroniser registers
    always_ff @(posedge WR_CLK) begin
        if (WR_RST) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            count_q <= count_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            sync_q[0] <= GRAY_RD_PTR;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign WR_ADDR        = wbin_q[AW-1:0];
    assign GRAY_WR_PTR    = gray_q;
    assign WR_FULL        = full_q;
    assign WR_ALMOST_FULL = afull_q;
    assign WR_COUNT       = count_q;
    assign WR_OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl_p.sv
// Scoreboard bench for fifo_wr_ctrl_p: a driver issues per-cycle stimulus
// and pushes the reference model's expectation; a monitor pops and compares.
module tb_fifo_wr_ctrl_p;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 2 * DEPTH;
    localparam int SS    = 2;
    localparam int TH    = 6;

    logic          WR_CLK = 1'b0;
    logic          WR_RST = 1'b0;
    logic          WR_INC = 1'b0;
    logic          OVF_CLR = 1'b0;
    logic [AW:0]   GRAY_RD_PTR = '0;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [AW:0]   GRAY_WR_PTR;
    logic          WR_FULL;
    logic          WR_ALMOST_FULL;
    logic [AW:0]   WR_COUNT;
    logic          WR_OVERFLOW;

    fifo_wr_ctrl_p #(
        .ADDR_WIDTH(AW),
        .SYNC_STAGES(SS),
        .AFULL_THRESH(TH)
    ) dut (
        .WR_CLK(WR_CLK),
        .WR_RST(WR_RST),
        .WR_INC(WR_INC),
        .OVF_CLR(OVF_CLR),
        .GRAY_RD_PTR(GRAY_RD_PTR),
        .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR),
        .GRAY_WR_PTR(GRAY_WR_PTR),
        .WR_FULL(WR_FULL),
        .WR_ALMOST_FULL(WR_ALMOST_FULL),
        .WR_COUNT(WR_COUNT),
        .WR_OVERFLOW(WR_OVERFLOW)
    );

    always #5 WR_CLK = ~WR_CLK;

    typedef struct {
        int wen;
        int addr;
        int gray;
        int full;
        int af;
        int cnt;
        int ovf;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model state: writes accepted, and the read pointers the
    // write side has not yet seen (oldest at index SS-1).
    int m_w = 0;
    int m_full = 0;
    int m_ovf = 0;
    int hist[SS];
    int rptr = 0;
    bit done = 0;

    function automatic int g2b(input int g);
        int b = 0;
        for (int i = g; i != 0; i = i >> 1) b = b ^ i;
        return b;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus; the model steps for the edge about to happen.
    task automatic cyc(input bit rst, input bit inc, input bit clr, input int rg);
        exp_t e;
        int wen, seen, cnt;
        @(negedge WR_CLK);
        WR_RST = rst;
        WR_INC = inc;
        OVF_CLR = clr;
        GRAY_RD_PTR = rg[AW:0];
        wen = (inc && !m_full) ? 1 : 0;
        e.wen = wen;
        if (rst) begin
            m_w = 0; m_full = 0; m_ovf = 0; cnt = 0;
            for (int i = 0; i < SS; i++) hist[i] = 0;
        end else begin
            seen = g2b(hist[SS-1]);
            m_ovf = ((inc && m_full) || (m_ovf && !clr)) ? 1 : 0;
            m_w = (m_w + wen) % MOD;
            cnt = (m_w - seen + MOD) % MOD;
            m_full = (cnt == DEPTH) ? 1 : 0;
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = rg;
        end
        e.addr = m_w % DEPTH;
        e.gray = b2g(m_w);
        e.full = m_full;
        e.af   = (cnt >= TH) ? 1 : 0;
        e.cnt  = cnt;
        e.ovf  = m_ovf;
        q.push_back(e);
    endtask

    // Monitor: write strobe checked mid-cycle, registered outputs after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge WR_CLK);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("wr_en", WR_EN, e.wen);
                @(posedge WR_CLK);
                #1;
                chk("wr_addr", WR_ADDR, e.addr);
                chk("gray_wr_ptr", GRAY_WR_PTR, e.gray);
                chk("wr_full", WR_FULL, e.full);
                chk("wr_almost_full", WR_ALMOST_FULL, e.af);
                chk("wr_count", WR_COUNT, e.cnt);
                chk("wr_overflow", WR_OVERFLOW, e.ovf);
            end
        end
    end

    // Driver
    initial begin
        int phase;
        for (int i = 0; i < SS; i++) hist[i] = 0;

        // Reset held with write request and a non-zero read pointer
        cyc(1, 1, 0, 4'b0101);
        cyc(1, 1, 0, 4'b0101);
        rptr = 0;

        // Fill to full, then overflow and its clear behaviour
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Release one slot; status must lag by the synchroniser depth
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, b2g(1));

        // Wrap with the read pointer tracking the writes
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            rptr = m_w;
            cyc(0, 1, 0, b2g(rptr));
        end

        // Mid-operation reset from count 5 with overflow set
        cyc(1, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, b2g(3));
        cyc(1, 1, 0, b2g(3));
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);

        // Randomised traffic with alternating fill/drain bias
        cyc(1, 0, 0, 0);
        rptr = 0;
        for (int n = 0; n < 3000; n++) begin
            phase = (n / 200) % 2;
            if ($urandom_range(0, 299) == 0) begin
                rptr = 0;
                cyc(1, $urandom_range(0, 1), 0, 0);
            end else begin
                if (rptr != m_w && $urandom_range(0, 3) < (phase ? 3 : 1))
                    rptr = (rptr + 1) % MOD;
                cyc(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), b2g(rptr));
            end
        end
        done = 1;
    end

    // Drain the scoreboard, then report
    initial begin
        wait (done);
        repeat (4) @(posedge WR_CLK);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
